// File: rtl/motor_pwm_driver_if.sv
// Motor speed request in, H-bridge drive and status out.
// motor is a level request sampled every clock (no valid/ready handshake); all outputs are registered.
interface motor_pwm_driver_if;
  logic [1:0]  motor;
  logic        pwm_a;
  logic        pwm_b;
  logic        dir;
  logic [15:0] duty;
  logic        moving;
  logic [1:0]  state_dbg;

  modport master (
    output motor,
    input  pwm_a, pwm_b, dir, duty, moving, state_dbg
  );

  modport slave (
    input  motor,
    output pwm_a, pwm_b, dir, duty, moving, state_dbg
  );
endinterface

// File: rtl/motor_pwm_driver.sv
// Ramped PWM H-bridge driver with ramp-down and dead time on direction reversal.
// state_dbg: 0 IDLE, 1 RUN, 2 DOWN, 3 DEAD.
module motor_pwm_driver #(
  parameter int unsigned PWM_PERIOD = 1000,
  parameter int unsigned DUTY_FOR   = 600,
  parameter int unsigned DUTY_FAST  = 900,
  parameter int unsigned DUTY_BACK  = 600,
  parameter int unsigned RAMP_STEP  = 10,
  parameter int unsigned RAMP_DIV   = 1000,
  parameter int unsigned DEAD_TIME  = 50
) (
  input logic               clk,
  input logic               rst,
  motor_pwm_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DOWN = 2'd2,
    DEAD = 2'd3
  } state_t;

  localparam logic [15:0] PERIOD_W = 16'(PWM_PERIOD);
  localparam logic [15:0] STEP_W   = 16'(RAMP_STEP);
  localparam logic [15:0] T_FOR    = 16'((DUTY_FOR  > PWM_PERIOD) ? PWM_PERIOD : DUTY_FOR);
  localparam logic [15:0] T_FAST   = 16'((DUTY_FAST > PWM_PERIOD) ? PWM_PERIOD : DUTY_FAST);
  localparam logic [15:0] T_BACK   = 16'((DUTY_BACK > PWM_PERIOD) ? PWM_PERIOD : DUTY_BACK);

  state_t      state;
  logic [1:0]  motor_q;
  logic [15:0] pcnt;
  logic [15:0] ramp;
  logic [15:0] duty_applied;
  logic [31:0] div_cnt;
  logic [31:0] dead_cnt;
  logic        dir;
  logic        pwm_a_q;
  logic        pwm_b_q;
  logic        moving_q;

  logic        req_stop;
  logic        req_dir;
  logic        reversal_pending;
  logic [15:0] target;
  logic [15:0] eff_target;
  logic        tick;
  logic [15:0] up_diff;
  logic [15:0] dn_diff;
  logic [15:0] ramp_nxt;
  logic [15:0] pcnt_nxt;
  logic [15:0] duty_nxt;
  logic        legs_enabled;
  logic        on_nxt;

  always_comb begin
    req_stop         = (motor_q == 2'b00);
    req_dir          = (motor_q == 2'b10);
    reversal_pending = !req_stop && (req_dir != dir);

    target = 16'd0;
    case (motor_q)
      2'b01:   target = T_FOR;
      2'b11:   target = T_FAST;
      2'b10:   target = T_BACK;
      default: target = 16'd0;
    endcase

    eff_target = (state == RUN && !req_stop && !reversal_pending) ? target : 16'd0;
    tick       = (div_cnt == RAMP_DIV - 1);
    up_diff    = eff_target - ramp;
    dn_diff    = ramp - eff_target;

    // The ramp only advances once the previous step has been applied, so the
    // applied duty changes by at most one step per PWM period.
    ramp_nxt = ramp;
    if (tick && ramp == duty_applied) begin
      if (ramp < eff_target)
        ramp_nxt = ramp + ((up_diff < STEP_W) ? up_diff : STEP_W);
      else if (ramp > eff_target)
        ramp_nxt = ramp - ((dn_diff < STEP_W) ? dn_diff : STEP_W);
    end

    pcnt_nxt     = (pcnt == PERIOD_W - 16'd1) ? 16'd0 : pcnt + 16'd1;
    duty_nxt     = (pcnt_nxt == 16'd0) ? ramp : duty_applied;
    legs_enabled = (state == RUN) || (state == DOWN);
    on_nxt       = (pcnt_nxt < duty_nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      motor_q      <= 2'b00;
      pcnt         <= 16'd0;
      ramp         <= 16'd0;
      duty_applied <= 16'd0;
      div_cnt      <= 32'd0;
      dead_cnt     <= 32'd0;
      dir          <= 1'b0;
      pwm_a_q      <= 1'b0;
      pwm_b_q      <= 1'b0;
      moving_q     <= 1'b0;
    end else begin
      motor_q      <= bus.motor;
      pcnt         <= pcnt_nxt;
      div_cnt      <= tick ? 32'd0 : div_cnt + 32'd1;
      ramp         <= ramp_nxt;
      duty_applied <= duty_nxt;
      moving_q     <= (duty_nxt != 16'd0);
      pwm_a_q      <= legs_enabled && !dir && on_nxt;
      pwm_b_q      <= legs_enabled &&  dir && on_nxt;

      // dir is only ever updated from IDLE or DEAD, where the applied duty is already 0.
      case (state)
        IDLE: begin
          if (!req_stop) begin
            dir   <= req_dir;
            state <= RUN;
          end
        end
        RUN: begin
          if (req_stop || reversal_pending)
            state <= DOWN;
        end
        DOWN: begin
          if (!req_stop && !reversal_pending) begin
            state <= RUN;
          end else if (ramp == 16'd0 && duty_applied == 16'd0) begin
            state    <= DEAD;
            dead_cnt <= 32'd0;
          end
        end
        DEAD: begin
          if (dead_cnt == DEAD_TIME - 1) begin
            dead_cnt <= 32'd0;
            if (req_stop) begin
              state <= IDLE;
            end else begin
              dir   <= req_dir;
              state <= RUN;
            end
          end else begin
            dead_cnt <= dead_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pwm_a     = pwm_a_q;
  assign bus.pwm_b     = pwm_b_q;
  assign bus.dir       = dir;
  assign bus.duty      = duty_applied;
  assign bus.moving    = moving_q;
  assign bus.state_dbg = state;

endmodule
